// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: the AXI read/write channel bundle between a bus master
// and the axi_sram_slave responder. The lock, cache and prot sideband fields
// are left out because the responder ignores them.
interface axi_sram_slave_if;
  // read address channel
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arid;
  logic        axi_arvalid;
  logic        axi_arready;
  // read data channel
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  // write address channel
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awid;
  logic        axi_awvalid;
  logic        axi_awready;
  // write data channel
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic [3:0]  axi_wid;
  logic        axi_wvalid;
  logic        axi_wready;
  // write response channel
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  modport slave (
    input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rid, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wid, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready
  );

  modport master (
    output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rid, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wid, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI responder backed by a 2^ADDR_W x 32-bit word SRAM.
// One read burst and one write burst in flight at a time, on independent
// channels. Optional feature macro AXI_SRAM_SLVERR_EN: report SLVERR for
// non-word transfer sizes and for write bursts whose wlast beat count does
// not match awlen+1 (data is still transferred).
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid and ready are both 1; a source holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module axi_sram_slave #(
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rset,
  axi_sram_slave_if.slave axi,
  output logic            o_rd_state,
  output logic [1:0]      o_wr_state
);

  typedef enum logic {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_t;

  logic [31:0] r_mem [0:(2**ADDR_W)-1];

  // read channel state
  rd_state_t          r_rd_state, w_rd_next;
  logic               r_arready;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [1:0]         r_rd_burst;
  logic [7:0]         r_rd_cnt;
  logic [31:0]        r_rdata;
  logic [3:0]         r_rid;
  logic               r_rvalid;
  logic               r_rlast;
  logic               w_ar_hs, w_r_hs;
  logic [ADDR_W-1:0]  w_ar_word, w_rd_addr_nxt;

  // write channel state
  wr_state_t          r_wr_state, w_wr_next;
  logic               r_awready;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [1:0]         r_wr_burst;
  logic [7:0]         r_awlen;
  logic [3:0]         r_awid;
  logic [8:0]         r_wbeats;
  logic [3:0]         r_bid;
  logic               w_aw_hs, w_w_hs, w_b_hs, w_mem_we;
  logic [ADDR_W-1:0]  w_wr_addr_nxt;

  assign w_ar_word     = axi.axi_araddr[ADDR_W+1:2];
  assign w_ar_hs       = axi.axi_arvalid & r_arready;
  assign w_r_hs        = r_rvalid & axi.axi_rready;
  // FIXED holds the address; INCR and WRAP both step by one word
  assign w_rd_addr_nxt = (r_rd_burst == 2'b00) ? r_rd_addr : r_rd_addr + ADDR_W'(1);

  assign w_aw_hs       = axi.axi_awvalid & r_awready;
  assign w_w_hs        = axi.axi_wvalid & (r_wr_state == WR_DATA);
  assign w_b_hs        = (r_wr_state == WR_RESP) & axi.axi_bready;
  assign w_wr_addr_nxt = (r_wr_burst == 2'b00) ? r_wr_addr : r_wr_addr + ADDR_W'(1);
  // beats past awlen+1 are dropped; the burst still runs until wlast
  assign w_mem_we      = w_w_hs & (r_wbeats <= {1'b0, r_awlen});

  // read FSM state register
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) r_rd_state <= RD_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  // read FSM next state
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:  if (w_ar_hs) w_rd_next = RD_BURST;
      RD_BURST: if (w_r_hs && r_rlast) w_rd_next = RD_IDLE;
      default:  w_rd_next = RD_IDLE;
    endcase
  end

  // read datapath: capture AR, prefetch each beat from the SRAM
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_arready  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_burst <= 2'b00;
      r_rd_cnt   <= 8'd0;
      r_rdata    <= 32'd0;
      r_rid      <= 4'd0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
    end else begin
      r_arready <= (w_rd_next == RD_IDLE);
      if (w_ar_hs) begin
        r_rid      <= axi.axi_arid;
        r_rd_addr  <= w_ar_word;
        r_rd_burst <= axi.axi_arburst;
        r_rd_cnt   <= axi.axi_arlen;
        r_rdata    <= r_mem[w_ar_word];
        r_rvalid   <= 1'b1;
        r_rlast    <= (axi.axi_arlen == 8'd0);
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
        end else begin
          r_rd_addr <= w_rd_addr_nxt;
          r_rd_cnt  <= r_rd_cnt - 8'd1;
          r_rdata   <= r_mem[w_rd_addr_nxt];
          r_rlast   <= (r_rd_cnt == 8'd1);
        end
      end
    end
  end

  // write FSM state register
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) r_wr_state <= WR_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  // write FSM next state
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_aw_hs) w_wr_next = WR_DATA;
      WR_DATA: if (w_w_hs && axi.axi_wlast) w_wr_next = WR_RESP;
      WR_RESP: if (w_b_hs) w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  // write datapath: capture AW, track address and beat count, form B
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_awready  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_burst <= 2'b00;
      r_awlen    <= 8'd0;
      r_awid     <= 4'd0;
      r_wbeats   <= 9'd0;
      r_bid      <= 4'd0;
    end else begin
      r_awready <= (w_wr_next == WR_IDLE);
      if (w_aw_hs) begin
        r_awid     <= axi.axi_awid;
        r_wr_addr  <= axi.axi_awaddr[ADDR_W+1:2];
        r_wr_burst <= axi.axi_awburst;
        r_awlen    <= axi.axi_awlen;
        r_wbeats   <= 9'd0;
      end else if (w_w_hs) begin
        r_wr_addr <= w_wr_addr_nxt;
        if (r_wbeats != 9'h1FF) r_wbeats <= r_wbeats + 9'd1;
        if (axi.axi_wlast) r_bid <= r_awid;
      end
    end
  end

  // SRAM byte-lane write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (axi.axi_wstrb[i]) r_mem[r_wr_addr][8*i +: 8] <= axi.axi_wdata[8*i +: 8];
      end
    end
  end

`ifdef AXI_SRAM_SLVERR_EN
  logic [1:0] r_rresp;
  logic [1:0] r_bresp;
  logic       r_wsize_err;

  // error responses: size checked at address time, beat count at wlast
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_rresp     <= 2'b00;
      r_bresp     <= 2'b00;
      r_wsize_err <= 1'b0;
    end else begin
      if (w_ar_hs) r_rresp <= (axi.axi_arsize != 3'b010) ? 2'b10 : 2'b00;
      if (w_aw_hs) r_wsize_err <= (axi.axi_awsize != 3'b010);
      if (w_w_hs && axi.axi_wlast)
        r_bresp <= (r_wsize_err || (r_wbeats != {1'b0, r_awlen})) ? 2'b10 : 2'b00;
    end
  end

  assign axi.axi_rresp = r_rresp;
  assign axi.axi_bresp = r_bresp;
`else
  assign axi.axi_rresp = 2'b00;
  assign axi.axi_bresp = 2'b00;
`endif

  assign axi.axi_arready = r_arready;
  assign axi.axi_rdata   = r_rdata;
  assign axi.axi_rid     = r_rid;
  assign axi.axi_rlast   = r_rlast;
  assign axi.axi_rvalid  = r_rvalid;
  assign axi.axi_awready = r_awready;
  assign axi.axi_wready  = (r_wr_state == WR_DATA);
  assign axi.axi_bid     = r_bid;
  assign axi.axi_bvalid  = (r_wr_state == WR_RESP);

  assign o_rd_state = r_rd_state;
  assign o_wr_state = r_wr_state;

  // fields this responder does not interpret
  logic w_unused;
  assign w_unused = ^{axi.axi_araddr[31:ADDR_W+2], axi.axi_araddr[1:0],
                      axi.axi_awaddr[31:ADDR_W+2], axi.axi_awaddr[1:0],
                      axi.axi_wid, axi.axi_arsize, axi.axi_awsize};

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI responder backed by an on-chip word-addressed SRAM, the slave-side counterpart of the CPU's AXI bus interface. It accepts one read burst and one write burst at a time, on independent channels. It serves as the bench target for cache refill/writeback traffic and as a small on-chip RAM on the SoC bus.

## Interface
- ADDR_W, 12, word-address bits; memory holds 2^ADDR_W 32-bit words, indexed by axi_*addr[ADDR_W+1:2].
- clk  in  1  sole clock, rising edge.
- rset  in  1  asynchronous, active-low reset.
- axi_araddr/arlen/arsize/arburst/arid  in  32/8/3/2/4  read address channel; arlock/arcache/arprot ignored.
- axi_arvalid in 1; axi_arready out 1.
- axi_rdata/rid/rresp/rlast  out  32/4/2/1  read data channel; axi_rvalid out 1; axi_rready in 1.
- axi_awaddr/awlen/awsize/awburst/awid  in  32/8/3/2/4  write address channel; awlock/awcache/awprot ignored.
- axi_awvalid in 1; axi_awready out 1.
- axi_wdata/wstrb/wlast/wid  in  32/4/1/4  write data (wid ignored); axi_wvalid in 1; axi_wready out 1.
- axi_bid/bresp  out  4/2  write response; axi_bvalid out 1; axi_bready in 1.

## Operation
- Read FSM RD_IDLE -> RD_BURST -> RD_IDLE. axi_arready=1 only in RD_IDLE.
- AR handshake: capture arid, word address, beat counter = arlen; load rdata = mem[addr]; rvalid=1; rlast = (arlen==0); go RD_BURST.
- RD_BURST, R handshake with rlast=0: address += 1 (burst FIXED: address held; WRAP treated as INCR); counter -= 1; load next word; rlast set when counter reaches 0. R handshake with rlast=1: rvalid=0, go RD_IDLE.
- rid = captured arid for the whole burst.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE. awready=1 only in WR_IDLE; wready=1 only in WR_DATA.
- AW handshake: capture awid, address, expected count = awlen.
- Each W handshake: write byte lanes of mem[addr] where wstrb[i]=1; advance address per burst type; increment beat count.
- On the W handshake with wlast=1: go WR_RESP, bvalid=1, bid = awid. Write data is discarded once beats reach awlen+1 without wlast. The burst still ends on wlast.
- WR_RESP: hold bvalid/bid/bresp until bready; then return to WR_IDLE.
- Address arithmetic is modulo 2^ADDR_W words; the upper address bits are ignored.
- Same-cycle read load and write to the same word: the read gets old data. The new data is visible from the next beat.
- Memory contents are not reset.

## Timing
- Reset values: arready=0, awready=0, wready=0, rvalid=0, rlast=0, bvalid=0, rresp=bresp=2'b00, rid=bid=0, rdata=0. Both FSMs in IDLE.
- arready and awready are registered. They rise on the first clk edge after rset deasserts.
- Read latency: AR handshake at edge N -> first beat valid after edge N; later beats 1/cycle while rready=1.
- rvalid, rdata and rlast stay stable while rready=0.
- Write throughput: 1 beat/cycle. wready rises the cycle after the AW handshake. bvalid rises the cycle after the wlast handshake.
- Earliest next AW accept is the cycle after the B handshake. The read channel is fully independent.
- rset low mid-burst: all outputs go to reset values at once, and the burst is abandoned. Partial writes already committed remain in memory.

## Configuration
- AXI_SRAM_SLVERR_EN defined:
  - rresp=2'b10 on every beat of a read burst whose arsize != 3'b010.
  - bresp=2'b10 when awsize != 3'b010.
  - bresp=2'b10 when the wlast beat count != awlen+1.
  - Data is still transferred in all these cases.
- AXI_SRAM_SLVERR_EN undefined: rresp and bresp are always 2'b00 (OKAY), and no size or beat-count checking is done.

## Test plan
- Reset release -> arready/awready=0 during reset, =1 one edge after. All valids stay 0.
- AW addr=0x100, len=3, INCR, wdata 0xA0..0xA3, wstrb=4'hF, bready=1 -> bvalid one cycle after the 4th beat, bid=awid, bresp=0. AR addr=0x100 len=3 -> 0xA0,0xA1,0xA2,0xA3, rlast on 4th beat.
- Read burst with rready toggled 1,0,0,1... -> rdata/rlast held stable during stalls, no beat skipped or repeated.
- Write 0x11223344 then wstrb=4'b0101 with 0xAABBCCDD to the same word -> readback 0x11BB33DD.
- Concurrent AR and AW to the same word in the same cycle -> first read beat returns old data, a later read returns new data.
- With AXI_SRAM_SLVERR_EN: awlen=3 but wlast on beat 2 -> bresp=2'b10. arsize=3'b001 -> rresp=2'b10 on every beat. Without the macro, both cases give 2'b00.
